// File: rtl/o_delay_ctrl_pkg.sv
// rtl/o_delay_ctrl_pkg.sv - shared types and helpers for the O_DELAY tap controller
package o_delay_ctrl_pkg;

    localparam int TAP_W = 6;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_GOTO = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] tap, input int max_tap);
        return (int'(tap) > max_tap) ? TAP_W'(max_tap) : tap;
    endfunction

endpackage

// File: rtl/o_delay_settle_cnt.sv
// rtl/o_delay_settle_cnt.sv - loadable down-counter with zero flag (settle window and stall count)
module o_delay_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/o_delay_tap_ctrl.sv
// rtl/o_delay_tap_ctrl.sv - closed-loop O_DELAY tap controller (LOAD/INC/DEC/GOTO)
// Optional macro O_DELAY_CTRL_INV_EN: active-low O_DELAY controls and inverted readback.
module o_delay_tap_ctrl
    import o_delay_ctrl_pkg::*;
#(
    parameter int MAX_TAP       = 63,
    parameter int SETTLE_CYCLES = 2,
    parameter int STEP_TIMEOUT  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [TAP_W-1:0] cmd_tap_i,
    output logic             dly_load_o,
    output logic             dly_adj_o,
    output logic             dly_incdec_o,
    input  logic [TAP_W-1:0] dly_tap_value_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [TAP_W-1:0] tap_o
);

`ifdef O_DELAY_CTRL_INV_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    localparam int               STALL_W     = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STEP_TIMEOUT - 1);
    localparam logic [TAP_W-1:0] MAX_T       = TAP_W'(MAX_TAP);

    state_e           state, next;
    cmd_op_e          op_q;
    logic [TAP_W-1:0] target_q;
    logic [TAP_W-1:0] tap_q;
    logic             incdec_q;
    logic             err_q;

    cmd_op_e          op_in;
    logic [TAP_W-1:0] target_in;
    logic [TAP_W-1:0] readback;
    logic             accept;
    logic             noop_in;
    logic             dir_in;
    logic             dir_chk;

    logic settle_load, settle_dec, settle_zero;
    logic stall_load, stall_dec, stall_zero;

    assign op_in     = cmd_op_e'(cmd_op_i);
    assign target_in = clamp_tap(cmd_tap_i, MAX_TAP);
    assign readback  = dly_tap_value_i ^ {TAP_W{POL}};
    assign accept    = cmd_valid_i && (state == ST_IDLE);

    // Commands that would not move the line finish without touching the primitive.
    assign noop_in = ((op_in == OP_GOTO) && (target_in == tap_q)) ||
                     ((op_in == OP_INC)  && (tap_q >= MAX_T))     ||
                     ((op_in == OP_DEC)  && (tap_q == '0));
    assign dir_in  = (op_in == OP_GOTO) ? (target_in > tap_q) : (op_in == OP_INC);
    assign dir_chk = (target_q > readback);

    o_delay_settle_cnt #(.W(4)) u_settle (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (settle_load),
        .load_val (SETTLE_LOAD),
        .dec      (settle_dec),
        .zero     (settle_zero)
    );

    o_delay_settle_cnt #(.W(STALL_W)) u_stall (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (stall_load),
        .load_val (STALL_LOAD),
        .dec      (stall_dec),
        .zero     (stall_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next        = state;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        stall_load  = 1'b0;
        stall_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next       = noop_in ? ST_DONE : ST_PULSE;
                    stall_load = 1'b1;
                end
            end
            ST_PULSE: begin
                next        = ST_SETTLE;
                settle_load = 1'b1;
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    next = ST_CHECK;
                end else begin
                    settle_dec = 1'b1;
                end
            end
            ST_CHECK: begin
                if ((op_q != OP_GOTO) || (readback == target_q)) begin
                    next = ST_DONE;
                end else if (readback != tap_q) begin
                    next       = ST_PULSE;
                    stall_load = 1'b1;
                end else if (stall_zero) begin
                    next = ST_ERR;
                end else begin
                    next        = ST_SETTLE;
                    stall_dec   = 1'b1;
                    settle_load = 1'b1;
                end
            end
            ST_DONE: next = ST_IDLE;
            ST_ERR:  next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= OP_LOAD;
            target_q <= '0;
            tap_q    <= '0;
            incdec_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= op_in;
                target_q <= target_in;
                incdec_q <= dir_in && !noop_in;
                err_q    <= 1'b0;
            end else if (next == ST_ERR) begin
                err_q <= 1'b1;
            end
            if (state == ST_CHECK) begin
                tap_q <= readback;
                if (next == ST_PULSE) begin
                    incdec_q <= dir_chk;
                end
            end
        end
    end

    // In IDLE the direction follows the offered command so it is set up a cycle ahead of the pulse.
    logic load_raw, adj_raw, incdec_raw;
    assign load_raw   = (state == ST_PULSE) && (op_q == OP_LOAD);
    assign adj_raw    = (state == ST_PULSE) && (op_q != OP_LOAD);
    assign incdec_raw = (state == ST_IDLE) ? (rst_ni && cmd_valid_i && dir_in && !noop_in) : incdec_q;

    assign dly_load_o   = load_raw ^ POL;
    assign dly_adj_o    = adj_raw ^ POL;
    assign dly_incdec_o = incdec_raw ^ POL;

    assign cmd_ready_o = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign done_o      = (state == ST_DONE) || (state == ST_ERR);
    assign err_o       = err_q;
    assign tap_o       = tap_q;

endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// tb/tb_o_delay_tap_ctrl.sv - directed self-checking bench for o_delay_tap_ctrl with an O_DELAY model
module tb_o_delay_tap_ctrl;

`ifdef O_DELAY_CTRL_INV_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_tap;
    logic       dly_load, dly_adj, dly_incdec;
    logic [5:0] dly_tap_value;
    logic       busy, done, err;
    logic [5:0] tap;

    logic [5:0] mtap = 6'd0;
    logic       frozen = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    o_delay_tap_ctrl #(
        .MAX_TAP       (40),
        .SETTLE_CYCLES (2),
        .STEP_TIMEOUT  (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_op_i        (cmd_op),
        .cmd_tap_i       (cmd_tap),
        .dly_load_o      (dly_load),
        .dly_adj_o       (dly_adj),
        .dly_incdec_o    (dly_incdec),
        .dly_tap_value_i (dly_tap_value),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .tap_o           (tap)
    );

    // Behavioural O_DELAY: load returns to tap 0, adj steps one tap without wrapping.
    assign dly_tap_value = (frozen ? 6'd5 : mtap) ^ {6{POL}};

    always @(posedge clk) begin
        if (dly_load ^ POL) begin
            mtap <= 6'd0;
        end else if (dly_adj ^ POL) begin
            if (dly_incdec ^ POL) begin
                if (mtap != 6'd63) mtap <= mtap + 6'd1;
            end else if (mtap != 6'd0) begin
                mtap <= mtap - 6'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] t, output logic pre_incdec);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_tap   = t;
        #1;
        pre_incdec = dly_incdec ^ POL;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output int up, output int dn);
        logic got;
        got = 1'b0;
        cyc = 0;
        up  = 0;
        dn  = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (dly_adj ^ POL) begin
                if (dly_incdec ^ POL) up++;
                else dn++;
            end
            if (done) got = 1'b1;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    initial begin
        int   cyc, up, dn;
        logic pre;

        rst_ni    = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_tap   = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_load", dly_load ^ POL, 0);
        check("rst_adj", dly_adj ^ POL, 0);
        check("rst_incdec", dly_incdec ^ POL, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tap", tap, 0);

        rst_ni = 1'b1;
        #1;
        check("no_accept_before_edge", busy, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("first_accept_busy", busy, 1);
        check("first_accept_ready", cmd_ready, 0);
        wait_done(20, cyc, up, dn);
        check("inc_latency", cyc, 5);
        check("inc_up", up, 1);
        check("inc_tap", tap, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        issue(2'd2, 6'd0, pre);
        wait_done(20, cyc, up, dn);
        check("dec_latency", cyc, 5);
        check("dec_dn", dn, 1);
        check("dec_tap", tap, 0);

        issue(2'd2, 6'd0, pre);
        wait_done(20, cyc, up, dn);
        check("dec_sat_latency", cyc, 1);
        check("dec_sat_pulses", up + dn, 0);
        check("dec_sat_err", err, 0);

        issue(2'd3, 6'd10, pre);
        check("goto10_setup_incdec", pre, 1);
        wait_done(100, cyc, up, dn);
        check("goto10_latency", cyc, 41);
        check("goto10_up", up, 10);
        check("goto10_dn", dn, 0);
        check("goto10_tap", tap, 10);
        check("goto10_model", mtap, 10);

        issue(2'd3, 6'd10, pre);
        wait_done(20, cyc, up, dn);
        check("goto_same_latency", cyc, 1);
        check("goto_same_pulses", up + dn, 0);

        issue(2'd3, 6'd63, pre);
        wait_done(300, cyc, up, dn);
        check("goto_clamp_latency", cyc, 121);
        check("goto_clamp_up", up, 30);
        check("goto_clamp_tap", tap, 40);
        check("goto_clamp_model", mtap, 40);

        issue(2'd1, 6'd0, pre);
        wait_done(20, cyc, up, dn);
        check("inc_sat_latency", cyc, 1);
        check("inc_sat_pulses", up + dn, 0);

        issue(2'd3, 6'd37, pre);
        check("goto_down_setup_incdec", pre, 0);
        wait_done(50, cyc, up, dn);
        check("goto_down_latency", cyc, 13);
        check("goto_down_dn", dn, 3);
        check("goto_down_tap", tap, 37);

        frozen = 1'b1;
        issue(2'd0, 6'd0, pre);
        wait_done(20, cyc, up, dn);
        check("load_frozen_latency", cyc, 5);
        check("load_frozen_tap", tap, 5);

        issue(2'd3, 6'd20, pre);
        wait_done(60, cyc, up, dn);
        check("stall_latency", cyc, 26);
        check("stall_pulses", up, 1);
        check("stall_err", err, 1);
        @(negedge clk);
        check("stall_done_once", done, 0);
        check("stall_err_sticky", err, 1);

        issue(2'd0, 6'd0, pre);
        check("err_cleared_on_accept", err, 0);
        wait_done(20, cyc, up, dn);
        check("load_after_err", err, 0);

        frozen = 1'b0;
        issue(2'd0, 6'd0, pre);
        wait_done(20, cyc, up, dn);
        check("load_tap", tap, 0);

        issue(2'd3, 6'd10, pre);
        cyc = 0;
        while (!(dly_adj ^ POL) && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_pulse_seen", dly_adj ^ POL, 1);
        rst_ni = 1'b0;
        #1;
        check("async_rst_adj", dly_adj ^ POL, 0);
        check("async_rst_adj_level", dly_adj, POL);
        check("async_rst_incdec_level", dly_incdec, POL);
        check("async_rst_load_level", dly_load, POL);
        check("async_rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_tap", tap, 0);
        check("post_rst_model", mtap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/o_delay_tap_ctrl.md
Name: o_delay_tap_ctrl

Overview:
- Control stage directly upstream of an O_DELAY primitive.
- Accepts tap commands over a valid/ready handshake and drives the O_DELAY DLY_LOAD, DLY_ADJ and DLY_INCDEC controls.
- Closes the loop on the primitive's DLY_TAP_VALUE readback, so the delay line reaches an absolute target tap.
- Reports done/error status to the test logic or host.

Parameters:
- MAX_TAP, 63: highest legal tap. Targets above it are clamped to MAX_TAP.
- SETTLE_CYCLES, 2: idle cycles after each control pulse before the readback is sampled. Range 1..15.
- STEP_TIMEOUT, 8: settle windows allowed without a tap change before an error is flagged.

Ports:
- clk_i  in  1  fabric clock; same buffered clock as O_DELAY CLK_IN
- rst_ni  in  1  reset, asynchronous assert, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  controller can accept a command (FSM in IDLE)
- cmd_op_i  in  2  0=LOAD, 1=INC, 2=DEC, 3=GOTO
- cmd_tap_i  in  6  target tap; used by GOTO only
- dly_load_o  out  1  to O_DELAY DLY_LOAD
- dly_adj_o  out  1  to O_DELAY DLY_ADJ
- dly_incdec_o  out  1  to O_DELAY DLY_INCDEC; 1=increment
- dly_tap_value_i  in  6  from O_DELAY DLY_TAP_VALUE
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle pulse when a command completes
- err_o  out  1  sticky step timeout; cleared by the next accepted command
- tap_o  out  6  registered copy of the last settled readback

Behaviour:
- Reset values: cmd_ready_o=1, dly_load_o=0, dly_adj_o=0, dly_incdec_o=0, busy_o=0, done_o=0, err_o=0, tap_o=0.
- Reset is asynchronous, so it takes effect mid-command. Any pulse in flight is dropped to 0 immediately.
- Handshake:
  - A command is accepted when cmd_valid_i && cmd_ready_o on a rising edge.
  - cmd_op_i and cmd_tap_i are captured in that cycle.
  - cmd_ready_o drops on the next cycle.
- FSM states: IDLE, PULSE, SETTLE, CHECK, DONE, ERR.
- IDLE: on accept, go to PULSE and clear err_o.
  - GOTO: first compare the clamped target with tap_o. If they are equal, go straight to DONE with no pulse.
- PULSE: exactly one cycle.
  - LOAD: dly_load_o=1.
  - INC, or GOTO with target > tap: dly_adj_o=1 and dly_incdec_o=1.
  - DEC, or GOTO with target < tap: dly_adj_o=1 and dly_incdec_o=0.
  - dly_incdec_o is held one cycle before and one cycle after the adj pulse (setup/hold). It is driven to its value from IDLE entry onward.
  - Next state: SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to CHECK.
- CHECK: sample dly_tap_value_i into tap_o.
  - LOAD, INC, DEC: go to DONE.
  - GOTO, readback == target: go to DONE.
  - GOTO, readback moved toward the target: go to PULSE.
  - GOTO, readback unchanged: increment the stall counter. Go to ERR when it reaches STEP_TIMEOUT; otherwise return to SETTLE.
- DONE: done_o=1 for one cycle, then IDLE.
- ERR: err_o=1 (sticky), done_o=1 for one cycle, then IDLE.
- Saturation:
  - INC at tap_o==MAX_TAP and DEC at tap_o==0 issue no pulse and complete in DONE.
  - Hardware wraparound is never exercised.
- Latency:
  - One INC/DEC/LOAD completes in 1 + SETTLE_CYCLES + 2 cycles from accept.
  - GOTO over a distance of N taps needs N*(SETTLE_CYCLES+2)+1 cycles.
- A new command offered while busy is held off by cmd_ready_o=0. It is never dropped.
- If cmd_valid_i and reset are released in the same cycle, there is no accept until the first edge with rst_ni=1.

Optional Feature:
- Macro: O_DELAY_CTRL_INV_EN.
- Defined: dly_load_o, dly_adj_o and dly_incdec_o are driven active-low, with an idle level of 1 and reset value 1. dly_tap_value_i is taken as bitwise-inverted before use, matching the inverted-control board wiring used in the delay test designs.
- Undefined: all control outputs and the readback are active-high, as described above.

Decomposition:
- Package o_delay_ctrl_pkg holds:
  - the cmd_op enum (LOAD/INC/DEC/GOTO);
  - the FSM state enum;
  - TAP_W=6.
- One sub-module is natural: o_delay_settle_cnt. It is a loadable down-counter with zero flag, used for SETTLE_CYCLES and for the stall count.
- Everything else stays in o_delay_tap_ctrl.

Test Plan:
- Reset with cmd_valid_i=1 held -> all outputs at reset values; first accept occurs only after rst_ni rises; cmd_ready_o=1 in IDLE.
- Behavioral O_DELAY model at tap 0, GOTO 10 -> exactly 10 adj pulses with incdec=1; done_o after 10*(2+2)+1=41 cycles; tap_o=10.
- GOTO 70 (cmd_tap_i is 6-bit, so drive the model/MAX_TAP=40 variant) -> clamped, ends at tap 40, no pulse beyond 40.
- DEC at tap 0 -> no dly_adj_o pulse, done_o one cycle later, err_o=0.
- Model frozen (readback stuck at 5), GOTO 20 -> err_o=1 after STEP_TIMEOUT=8 stalled windows, done_o pulses once; the next LOAD clears err_o.
- Assert rst_ni low mid-pulse of a GOTO -> dly_adj_o=0 in the same cycle; FSM in IDLE after release; built with O_DELAY_CTRL_INV_EN, the same test shows idle levels of 1.
